// File: rtl/max_pool_2x2.sv
// -----------------------------------------------------------------------------
// max_pool_2x2
//   Streaming 2x2 / stride-2 max-pooling stage feeding the dense layer buffer.
//   Pixels arrive channel-major, raster order inside each channel, with no
//   backpressure. Each pooled value is written out with a linear address
//   (channel*(IMG_W/2)*(IMG_H/2) + prow*(IMG_W/2) + pcol).
//
//   Optional build macro: MAXPOOL_RELU_EN -- when defined, a ReLU is fused on
//   the output (negative maxima become 0); timing is identical either way.
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle pulse: arm for a new frame, clear counters/address
//   in_valid  in   in_data carries a pixel this cycle
//   in_data   in   signed pixel [dataWidthMax-1:0]
//   out_valid out  one-cycle pulse per pooled value
//   out_data  out  signed pooled maximum [dataWidthMax-1:0]
//   out_addr  out  write address [addressWidthConv-1:0]
//   busy      out  high in RUN and FLUSH
//   done      out  one-cycle pulse in the cycle after the last out_valid
//
// Handshake: in_valid qualifies in_data on the rising edge; there is no ready,
// every valid pixel in RUN (or coincident with start) is consumed. out_valid is
// a single-cycle strobe qualifying out_data/out_addr; the consumer must take it.
//
// The FSM state is the signal "state" (state_t) for checkers to bind to.
// -----------------------------------------------------------------------------
module max_pool_2x2 #(
  parameter int dataWidthMax     = 8,
  parameter int addressWidthConv = 10,
  parameter int IMG_W            = 26,
  parameter int IMG_H            = 26,
  parameter int NUM_CH           = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [dataWidthMax-1:0]     in_data,
  output logic                        out_valid,
  output logic [dataWidthMax-1:0]     out_data,
  output logic [addressWidthConv-1:0] out_addr,
  output logic                        busy,
  output logic                        done
);

  // Column counter is at least 2 bits so col[CW-1:1] (the line-buffer index)
  // is always a legal slice; for even IMG_W, clog2(IMG_W)-1 == clog2(IMG_W/2).
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int LW = CW - 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = dataWidthMax;
  localparam int AW = addressWidthConv;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] col, col_eff, col_nx;
  logic [RW-1:0] row, row_eff, row_nx;
  logic [HW-1:0] ch, ch_eff, ch_nx;
  logic [AW-1:0] addr, addr_eff;

  logic accept;
  logic win;
  logic last_px;

  logic signed [DW-1:0] px_s;
  logic signed [DW-1:0] pair_reg;
  logic signed [DW-1:0] hmax;
  logic signed [DW-1:0] lb_rd;
  logic signed [DW-1:0] vmax;
  logic        [LW-1:0] lb_idx;

  logic signed [DW-1:0] line_buf [2**LW];

  assign px_s = in_data;

  // start zeroes the counters in the same cycle it is seen, so a pixel that
  // arrives together with start is pixel (0,0,0) of the new frame.
  always_comb begin
    col_eff  = start ? '0 : col;
    row_eff  = start ? '0 : row;
    ch_eff   = start ? '0 : ch;
    addr_eff = start ? '0 : addr;
    accept   = in_valid && (start || (state == S_RUN));
    win      = accept && col_eff[0] && row_eff[0];
    last_px  = accept && (col_eff == CW'(IMG_W - 1))
                      && (row_eff == RW'(IMG_H - 1))
                      && (ch_eff  == HW'(NUM_CH - 1));
  end

  // Raster counters: col wraps into row, row wraps into ch.
  always_comb begin
    col_nx = col_eff;
    row_nx = row_eff;
    ch_nx  = ch_eff;
    if (accept) begin
      if (col_eff == CW'(IMG_W - 1)) begin
        col_nx = '0;
        if (row_eff == RW'(IMG_H - 1)) begin
          row_nx = '0;
          ch_nx  = (ch_eff == HW'(NUM_CH - 1)) ? '0 : ch_eff + 1'b1;
        end else begin
          row_nx = row_eff + 1'b1;
        end
      end else begin
        col_nx = col_eff + 1'b1;
      end
    end
  end

  // Next-state logic. start from any state (re)enters RUN; aborting a frame
  // therefore never visits DONE.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = S_RUN;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_IDLE;
        S_RUN:   if (last_px) state_nx = S_FLUSH;
        S_FLUSH: state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_FLUSH);
  assign done = (state == S_DONE);

  // Horizontal max of the pixel pair, then vertical max against the pair
  // result stored from the even row above.
  always_comb begin
    lb_idx = col_eff[CW-1:1];
    lb_rd  = line_buf[lb_idx];
    hmax   = (pair_reg > px_s) ? pair_reg : px_s;
    vmax   = (lb_rd > hmax) ? lb_rd : hmax;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      ch        <= '0;
      addr      <= '0;
      pair_reg  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      state     <= state_nx;
      col       <= col_nx;
      row       <= row_nx;
      ch        <= ch_nx;
      out_valid <= win;
      if (accept && !col_eff[0]) begin
        pair_reg <= px_s;
      end
      if (win) begin
`ifdef MAXPOOL_RELU_EN
        out_data <= vmax[DW-1] ? '0 : vmax;
`else
        out_data <= vmax;
`endif
        out_addr <= addr_eff;
        addr     <= addr_eff + 1'b1;
      end else begin
        addr     <= addr_eff;
      end
    end
  end

  // Line buffer holds don't-care data at reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && col_eff[0] && !row_eff[0]) begin
      line_buf[lb_idx] <= hmax;
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// -----------------------------------------------------------------------------
// tb_max_pool_2x2
//   Self-checking bench for max_pool_2x2. Two instances share clock and reset:
//   a default-geometry one (26x26x3) and a single-window one (2x2x1).
//   Expected {addr,data} pairs are queued when the completing pixel is driven;
//   monitors on the falling edge pop and compare whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_max_pool_2x2;

  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int W    = 26;
  localparam int H    = 26;
  localparam int C    = 3;
  localparam int NOUT = (W / 2) * (H / 2) * C;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // default-geometry instance
  logic          start, in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy, done;

  max_pool_2x2 #(.dataWidthMax(DW), .addressWidthConv(AW),
                 .IMG_W(W), .IMG_H(H), .NUM_CH(C)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done)
  );

  // single-window instance
  logic          s_start, s_in_valid;
  logic [DW-1:0] s_in_data;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [AW-1:0] s_out_addr;
  logic          s_busy, s_done;

  max_pool_2x2 #(.dataWidthMax(DW), .addressWidthConv(AW),
                 .IMG_W(2), .IMG_H(2), .NUM_CH(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_addr(s_out_addr),
    .busy(s_busy), .done(s_done)
  );

  // scoreboard state
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_s_q[$];
  int out_cnt = 0, s_out_cnt = 0, done_cnt = 0, s_done_cnt = 0, push_cnt = 0;
  logic prev_last = 1'b0, s_prev_last = 1'b0;
  logic [AW+DW-1:0] mon_e, mon_s_e;
  int pix [C][H][W];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pool4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m[DW-1:0];
  endfunction

  // monitors
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL out_unexpected: out_valid with addr 0x%0h data 0x%0h, expected none",
                   out_addr, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_addr", 32'(out_addr), 32'(mon_e[AW+DW-1:DW]));
          check("out_data", 32'(out_data), 32'(mon_e[DW-1:0]));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_out", 32'(prev_last), 32'd1);
      end
      prev_last = out_valid && (out_addr == AW'(NOUT - 1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (s_out_valid) begin
        s_out_cnt++;
        if (exp_s_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL s_out_unexpected: out_valid with addr 0x%0h data 0x%0h, expected none",
                   s_out_addr, s_out_data);
        end else begin
          mon_s_e = exp_s_q.pop_front();
          check("s_out_addr", 32'(s_out_addr), 32'(mon_s_e[AW+DW-1:DW]));
          check("s_out_data", 32'(s_out_data), 32'(mon_s_e[DW-1:0]));
        end
      end
      if (s_done) begin
        s_done_cnt++;
        check("s_done_after_last_out", 32'(s_prev_last), 32'd1);
      end
      s_prev_last = s_out_valid && (s_out_addr == '0);
    end
  end

  // driver tasks (all driving happens 1ns after a rising edge)
  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic px(input logic [DW-1:0] d, input logic st);
    start    = st;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic s_px(input logic [DW-1:0] d);
    s_in_valid = 1'b1;
    s_in_data  = d;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic s_pulse_start();
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
  endtask

  // Drives the first npix pixels of a random frame; the first pixel carries
  // start when with_start is set. Expected values come from the stored frame.
  task automatic send_frame(input int npix, input bit with_start);
    int idx;
    int v;
    int a;
    idx = 0;
    for (int c = 0; c < C; c++) begin
      for (int r = 0; r < H; r++) begin
        for (int k = 0; k < W; k++) begin
          if (idx < npix) begin
            v = $signed(DW'($urandom_range(0, 255)));
            pix[c][r][k] = v;
            if ((r % 2 == 1) && (k % 2 == 1)) begin
              a = c * (W / 2) * (H / 2) + (r / 2) * (W / 2) + k / 2;
              exp_q.push_back({AW'(a),
                               pool4(pix[c][r-1][k-1], pix[c][r-1][k], pix[c][r][k-1], v)});
              push_cnt++;
            end
            px(DW'(v), with_start && (idx == 0));
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 4));
          end
          idx++;
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (((exp_q.size() != 0) || (exp_s_q.size() != 0)) && (t < 200)) begin
      gap(1);
      t++;
    end
    check(name, 32'(exp_q.size() + exp_s_q.size()), 32'd0);
    gap(3);
  endtask

  initial begin
    int s_done_ref;
    int s_out_ref;
    start = 0; in_valid = 0; in_data = 0;
    s_start = 0; s_in_valid = 0; s_in_data = 0;
    rst = 1'b0;

    // reset held with random inputs
    repeat (5) begin
      @(posedge clk);
      #1;
      start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data = DW'($urandom);
      s_start = 1'($urandom_range(0, 1));
      s_in_valid = 1'($urandom_range(0, 1));
      s_in_data = DW'($urandom);
    end
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_addr",  32'(out_addr),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_s_busy",    32'(s_busy),    32'd0);
    start = 0; in_valid = 0; s_start = 0; s_in_valid = 0;
    rst = 1'b1;
    gap(2);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);

    // full default frame with random gaps
    out_cnt = 0; push_cnt = 0; done_cnt = 0;
    send_frame(W * H * C, 1'b0);
    drain("frame1_drain");
    check("frame1_out_count", 32'(out_cnt), 32'(NOUT));
    check("frame1_done_count", 32'(done_cnt), 32'd1);
    check("frame1_busy_end", 32'(busy), 32'd0);

    // pixels after the final one are ignored
    repeat (6) px(DW'($urandom), 1'b0);
    gap(3);
    check("post_frame_out_count", 32'(out_cnt), 32'(NOUT));

    // abort after 100 pixels, then full frame started coincident with pixel 0
    out_cnt = 0; push_cnt = 0; done_cnt = 0;
    pulse_start();
    send_frame(100, 1'b0);
    check("abort_busy", 32'(busy), 32'd1);
    send_frame(W * H * C, 1'b1);
    drain("frame2_drain");
    check("frame2_out_count", 32'(out_cnt), 32'(push_cnt));
    check("frame2_done_count", 32'(done_cnt), 32'd1);

    // single window: 5,-3,7,2 -> 7
    s_pulse_start();
    check("s_busy_after_start", 32'(s_busy), 32'd1);
    s_px(8'd5); s_px(-8'sd3); s_px(8'd7);
    exp_s_q.push_back({AW'(0), 8'd7});
    s_px(8'd2);
    drain("s_win1_drain");

    // signed: -128,-1,-50,-2 -> -1 (0 with ReLU)
    s_pulse_start();
    s_px(8'h80); s_px(8'hFF); s_px(8'hCE);
`ifdef MAXPOOL_RELU_EN
    exp_s_q.push_back({AW'(0), 8'h00});
`else
    exp_s_q.push_back({AW'(0), 8'hFF});
`endif
    s_px(8'hFE);
    drain("s_win2_drain");

    // maximum in the upper-right position: 9,100,-5,99 -> 100
    s_pulse_start();
    s_px(8'd9); s_px(8'd100); s_px(-8'sd5);
    exp_s_q.push_back({AW'(0), 8'd100});
    s_px(8'd99);
    drain("s_win3_drain");
    check("s_done_count", 32'(s_done_cnt), 32'd3);
    check("s_out_count", 32'(s_out_cnt), 32'd3);

    // extra pixels with no start: ignored
    s_px(8'd1); s_px(8'd2); s_px(8'd3); s_px(8'd4);
    gap(3);
    check("s_ignored_out_count", 32'(s_out_cnt), 32'd3);

    // async reset right after the completing pixel's edge
    s_done_ref = s_done_cnt;
    s_out_ref = s_out_cnt;
    s_pulse_start();
    s_px(8'd1); s_px(8'd2); s_px(8'd3);
    s_in_valid = 1'b1;
    s_in_data = 8'd4;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_in_valid = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(s_out_valid), 32'd0);
    check("rstmid_busy", 32'(s_busy), 32'd0);
    check("rstmid_out_addr", 32'(s_out_addr), 32'd0);
    gap(2);
    rst = 1'b1;
    gap(4);
    check("rstmid_no_done", 32'(s_done_cnt), 32'(s_done_ref));
    check("rstmid_no_out", 32'(s_out_cnt), 32'(s_out_ref));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
